cpu_move_sched: RTL and testbench
=================================

CPU_MOVE_SCHED -- requirements
Module: cpu_move_sched

Interface
REQ-001 SHALL provide parameter: MAX_TRIES, 8, number of random probes before falling back to a linear scan (legal range 1..15).
REQ-002 SHALL provide port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL provide port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL provide port: start  input  1  request one computer move; sampled only in IDLE.
REQ-005 SHALL provide port: occupied  input  16  board occupancy map, bit i = 1 means cell i is taken.
REQ-006 SHALL provide port: busy  output  1  high from the cycle after an accepted start through the done cycle, inclusive.
REQ-007 SHALL provide port: done  output  1  one-cycle pulse marking that pos and full are valid.
REQ-008 SHALL provide port: pos  output  4  selected free cell index; holds its value until the next done.
REQ-009 SHALL provide port: full  output  1  valid with done; 1 means no free cell exists and pos = 0.

Function
REQ-010 SHALL contain a 5-bit LFSR that free-runs every cycle: lfsr <= {lfsr[3:0], lfsr[4]^lfsr[2]}, with period 31.
REQ-011 SHALL use lfsr[3:0] as the candidate cell, so that all 16 cells are reachable.
REQ-012 SHALL implement states IDLE, SEARCH, SCAN, DONE; DONE always returns to IDLE after one cycle.
REQ-013 SHALL, on an accepted start in IDLE, latch occupied into a snapshot, clear the tries counter and scan index, and go to SEARCH.
REQ-014 SHALL ignore changes on occupied after the snapshot is taken, until the next accepted start.
REQ-015 SHALL ignore start while in SEARCH, SCAN or DONE; start is not queued.
REQ-016 SHALL, in SEARCH, test snapshot[lfsr[3:0]] each cycle:
- if 0, latch pos = lfsr[3:0] and go to DONE;
- otherwise increment tries.
REQ-017 SHALL go from SEARCH to SCAN when a miss occurs with tries = MAX_TRIES-1, so that exactly MAX_TRIES probes are made.
REQ-018 SHALL, in SCAN, test cell index 0,1,2,... one index per cycle; at the first index whose snapshot bit is 0 it latches pos = index and goes to DONE.
REQ-019 SHALL, if the snapshot equals 16'hFFFF, go from SEARCH directly to DONE on the first SEARCH cycle, with full=1 and pos=0 and no probing.
REQ-020 SHALL, when full=0, always deliver a pos whose snapshot bit is 0.
REQ-021 SHALL have latency of 2 cycles from accepted start to done on a first-probe hit, and at most MAX_TRIES+17 cycles in the worst case.
REQ-022 SHALL clear full on the next done that finds a free cell.

Reset
REQ-023 SHALL, on reset, set state to IDLE, busy=0, done=0, pos=0, full=0, tries=0, scan index=0, snapshot=0 and lfsr=5'b00001.
REQ-024 SHALL treat reset asserted mid-search as an abort: no done pulse is produced and the next cycle is in IDLE.
REQ-025 SHALL give reset priority over start in the same cycle.

Configuration
REQ-026 SHALL provide macro CPU_MOVE_TRY_COUNT_EN.
REQ-027 SHALL, when CPU_MOVE_TRY_COUNT_EN is defined:
- add output tries_used (4 bits, reset 0), valid with done;
- tries_used = number of SEARCH probes made (1..MAX_TRIES), 15 if SCAN was entered, and 0 when full=1.
REQ-028 SHALL, when CPU_MOVE_TRY_COUNT_EN is undefined, omit the port and all of its logic; all other behaviour is identical.

Verification
REQ-029 SHALL check: occupied=16'h0000, start pulsed -> done 2 cycles later, full=0, pos equals the lfsr[3:0] value predicted by a bench reference LFSR.
REQ-030 SHALL check: occupied=16'hFFFF, start pulsed -> done 2 cycles later, full=1, pos=0, busy high for exactly 2 cycles.
REQ-031 SHALL check: occupied=16'hFFFE, MAX_TRIES=1 -> SCAN entered, pos=0 on the first scan cycle, done within 4 cycles; with the macro, tries_used=15.
REQ-032 SHALL check: occupied=16'h7FFF, occupied toggled to 16'hFFFF during SEARCH -> pos=15, full=0, confirming the snapshot is used.
REQ-033 SHALL check: start held high continuously for 200 cycles with random occupied (not full) -> one done per IDLE entry, pos always a free cell, never stuck.
REQ-034 SHALL check: reset asserted in the second SEARCH cycle -> no done, busy=0 and pos=0 next cycle, lfsr=5'b00001.

Source files
------------

// File: rtl/cpu_move_sched.sv
// Picks a free board cell for the computer's move using random LFSR probes, then a linear scan.
// Optional tries_used output when CPU_MOVE_TRY_COUNT_EN is defined.
module cpu_move_sched #(
    parameter int unsigned MAX_TRIES = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] occupied,
    output logic        busy,
    output logic        done,
    output logic [3:0]  pos,
    output logic        full
`ifdef CPU_MOVE_TRY_COUNT_EN
    ,
    output logic [3:0]  tries_used
`endif
);

    typedef enum logic [1:0] {StIdle, StSearch, StScan, StDone} state_e;

    localparam logic [3:0] LastTry = 4'(MAX_TRIES - 1);

    state_e      state_q;
    logic [4:0]  lfsr_q;
    logic [15:0] snapshot_q;
    logic [3:0]  tries_q;
    logic [3:0]  scan_idx_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            lfsr_q     <= 5'b00001;
            snapshot_q <= 16'h0000;
            tries_q    <= 4'd0;
            scan_idx_q <= 4'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pos        <= 4'd0;
            full       <= 1'b0;
`ifdef CPU_MOVE_TRY_COUNT_EN
            tries_used <= 4'd0;
`endif
        end else begin
            // Free-running, independent of the search state.
            lfsr_q <= {lfsr_q[3:0], lfsr_q[4] ^ lfsr_q[2]};
            done   <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        snapshot_q <= occupied;
                        tries_q    <= 4'd0;
                        scan_idx_q <= 4'd0;
                        busy       <= 1'b1;
                        state_q    <= StSearch;
                    end
                end
                StSearch: begin
                    if (snapshot_q == 16'hFFFF) begin
                        pos     <= 4'd0;
                        full    <= 1'b1;
                        done    <= 1'b1;
                        state_q <= StDone;
`ifdef CPU_MOVE_TRY_COUNT_EN
                        tries_used <= 4'd0;
`endif
                    end else if (!snapshot_q[lfsr_q[3:0]]) begin
                        pos     <= lfsr_q[3:0];
                        full    <= 1'b0;
                        done    <= 1'b1;
                        state_q <= StDone;
`ifdef CPU_MOVE_TRY_COUNT_EN
                        tries_used <= tries_q + 4'd1;
`endif
                    end else begin
                        tries_q <= tries_q + 4'd1;
                        if (tries_q == LastTry) begin
                            state_q <= StScan;
                        end
                    end
                end
                StScan: begin
                    // Snapshot is known not full here, so a free index is always found.
                    if (!snapshot_q[scan_idx_q]) begin
                        pos     <= scan_idx_q;
                        full    <= 1'b0;
                        done    <= 1'b1;
                        state_q <= StDone;
`ifdef CPU_MOVE_TRY_COUNT_EN
                        tries_used <= 4'd15;
`endif
                    end else begin
                        scan_idx_q <= scan_idx_q + 4'd1;
                    end
                end
                StDone: begin
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_move_sched.sv
// Randomized self-checking bench for cpu_move_sched against a move-level reference model.
// Two instances: MAX_TRIES=8 (main) and MAX_TRIES=1 (scan fallback).
module tb_cpu_move_sched;

    logic        clk = 1'b0;
    logic        reset;
    logic        start0, start1;
    logic [15:0] occupied;
    logic        busy0, done0, full0, busy1, done1, full1;
    logic [3:0]  pos0, pos1;
`ifdef CPU_MOVE_TRY_COUNT_EN
    logic [3:0]  tu0, tu1;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    logic [4:0] ref_lfsr;

    always #5 clk = ~clk;

    cpu_move_sched #(.MAX_TRIES(8)) u_dut0 (
        .clk(clk), .reset(reset), .start(start0), .occupied(occupied),
        .busy(busy0), .done(done0), .pos(pos0), .full(full0)
`ifdef CPU_MOVE_TRY_COUNT_EN
        , .tries_used(tu0)
`endif
    );

    cpu_move_sched #(.MAX_TRIES(1)) u_dut1 (
        .clk(clk), .reset(reset), .start(start1), .occupied(occupied),
        .busy(busy1), .done(done1), .pos(pos1), .full(full1)
`ifdef CPU_MOVE_TRY_COUNT_EN
        , .tries_used(tu1)
`endif
    );

    function automatic logic [4:0] lfsr_next(input logic [4:0] l);
        return {l[3:0], l[4] ^ l[2]};
    endfunction

    // Reference LFSR value for the current cycle.
    always @(posedge clk) ref_lfsr <= reset ? 5'b00001 : lfsr_next(ref_lfsr);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Outcome of one move given the snapshot and the LFSR value in the first SEARCH cycle.
    function automatic void predict(input logic [15:0] snap, input logic [4:0] l0, input int mt,
                                    output int lat, output logic [3:0] p, output logic f,
                                    output logic [3:0] tu);
        logic [4:0] l;
        l = l0;
        lat = 2; p = 4'd0; f = 1'b1; tu = 4'd0;
        if (snap == 16'hFFFF) return;
        f = 1'b0;
        for (int k = 0; k < mt; k++) begin
            if (!snap[l[3:0]]) begin
                lat = 2 + k; p = l[3:0]; tu = 4'(k + 1);
                return;
            end
            l = lfsr_next(l);
        end
        for (int i = 0; i < 16; i++) begin
            if (!snap[i]) begin
                lat = 2 + mt + i; p = 4'(i); tu = 4'd15;
                return;
            end
        end
    endfunction

    // Called in an IDLE cycle; returns in the IDLE cycle after done.
    task automatic run_move(input int sel, input logic [15:0] occ, input logic [15:0] occ_after,
                            input bit hold, output int n_out);
        int         mt, lat, n;
        logic [3:0] ep, etu, p;
        logic       ef;
        bit         busy_ok, seen;
        mt = (sel != 0) ? 1 : 8;
        occupied = occ;
        if (sel != 0) start1 = 1'b1; else start0 = 1'b1;
        predict(occ, lfsr_next(ref_lfsr), mt, lat, ep, ef, etu);
        busy_ok = 1'b1; seen = 1'b0; n = 0;
        while (!seen && n < 40) begin
            @(posedge clk); #1;
            n++;
            if (!hold) begin start0 = 1'b0; start1 = 1'b0; end
            occupied = occ_after;
            if (((sel != 0) ? busy1 : busy0) !== 1'b1) busy_ok = 1'b0;
            if (((sel != 0) ? done1 : done0) === 1'b1) seen = 1'b1;
        end
        p = (sel != 0) ? pos1 : pos0;
        check("done_seen", 32'(seen), 32'd1);
        check("latency", n, lat);
        check("pos", 32'(p), 32'(ep));
        check("full", 32'((sel != 0) ? full1 : full0), 32'(ef));
        check("pos_free", 32'(occ[p]), 32'(ef));
        check("busy_span", 32'(busy_ok), 32'd1);
`ifdef CPU_MOVE_TRY_COUNT_EN
        check("tries_used", 32'((sel != 0) ? tu1 : tu0), 32'(etu));
`endif
        @(posedge clk); #1;
        check("idle_busy", 32'((sel != 0) ? busy1 : busy0), 32'd0);
        check("idle_done", 32'((sel != 0) ? done1 : done0), 32'd0);
        n_out = n;
    endtask

    function automatic logic [15:0] rand_not_full();
        logic [15:0] occ;
        occ = 16'($urandom);
        if ($urandom_range(0, 1) == 1) occ = occ | 16'($urandom) | 16'($urandom);
        if (occ == 16'hFFFF) occ[$urandom_range(0, 15)] = 1'b0;
        return occ;
    endfunction

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int          n, cycles;
        logic [15:0] occ;
        logic [4:0]  l0;
        logic [3:0]  c0, c1, f;

        reset = 1'b1; start0 = 1'b0; start1 = 1'b0; occupied = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy0), 32'd0);
        check("rst_done", 32'(done0), 32'd0);
        check("rst_pos", 32'(pos0), 32'd0);
        check("rst_full", 32'(full0), 32'd0);
        check("rst_lfsr", 32'(u_dut0.lfsr_q), 32'd1);
`ifdef CPU_MOVE_TRY_COUNT_EN
        check("rst_tries_used", 32'(tu0), 32'd0);
`endif
        reset = 1'b0;
        @(posedge clk); #1;

        run_move(0, 16'h0000, 16'h0000, 1'b0, n);
        check("empty_lat2", n, 2);
        run_move(0, 16'hFFFF, 16'hFFFF, 1'b0, n);
        check("full_flag", 32'(full0), 32'd1);
        run_move(1, 16'hFFFE, 16'hFFFE, 1'b0, n);
        check("scan_within4", 32'(n <= 4), 32'd1);
        check("scan_pos0", 32'(pos1), 32'd0);
        run_move(0, 16'h7FFF, 16'hFFFF, 1'b0, n);
        check("snap_pos15", 32'(pos0), 32'd15);
        check("snap_full0", 32'(full0), 32'd0);

        repeat (30) begin
            occ = ($urandom_range(0, 7) == 0) ? 16'hFFFF : rand_not_full();
            run_move(int'($urandom_range(0, 1)), occ, 16'($urandom), 1'b0, n);
        end

        // start held high across many moves
        cycles = 0;
        while (cycles < 200) begin
            run_move(0, rand_not_full(), 16'($urandom), 1'b1, n);
            cycles += n + 1;
        end
        start0 = 1'b0;
        @(posedge clk); #1;

        run_move(0, 16'h7FFF, 16'h7FFF, 1'b0, n);
        // Abort: choose a free cell missed by the first two probes.
        l0 = lfsr_next(ref_lfsr);
        c0 = l0[3:0];
        l0 = lfsr_next(l0);
        c1 = l0[3:0];
        f = 4'd0;
        for (int i = 0; i < 16; i++) if (4'(i) != c0 && 4'(i) != c1) f = 4'(i);
        occupied = ~(16'h0001 << f);
        start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        check("abort_no_done1", 32'(done0), 32'd0);
        @(posedge clk); #1;
        check("abort_no_done2", 32'(done0), 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort_done", 32'(done0), 32'd0);
        check("abort_busy", 32'(busy0), 32'd0);
        check("abort_pos", 32'(pos0), 32'd0);
        check("abort_lfsr", 32'(u_dut0.lfsr_q), 32'd1);
        repeat (3) begin
            @(posedge clk); #1;
            check("abort_quiet", 32'(done0), 32'd0);
        end
        run_move(0, 16'h00F0, 16'hFFFF, 1'b0, n);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
